uart_tx_cfg: RTL and testbench
==============================

Name: uart_tx_cfg

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 transmitter. Data width, parity mode, stop-bit count and baud divisor are set at elaboration time. A valid/ready handshake, a busy flag and a frame-done pulse let an upstream FIFO or controller stream bytes without external timing. It sits between the system-clock datapath and the TX pin.

Parameters:
CLK_DIV, 434, system clocks per bit; 50 MHz / 115200. Legal range is 2 or more.
DATA_BITS, 8, payload bits per frame. Legal range is 5..9.
PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, stop bits per frame. Legal values are 1 or 2.

Ports:
clk  input  1  system clock.
rst_n  input  1  reset.
din  input  DATA_BITS  payload, LSB transmitted first.
din_vld  input  1  upstream has data.
din_rdy  output  1  transmitter can accept data.
dout  output  1  serial line, idle high.
busy  output  1  frame in progress.
tx_done  output  1  one-cycle pulse at end of frame.

Behaviour:
- Reset: rst_n, asynchronous, active-low; clock clk.
- Reset values: dout=1, din_rdy=1, busy=0, tx_done=0. The FSM resets to IDLE and all counters to 0.
- Reset mid-frame aborts the frame. dout returns high asynchronously and no tx_done pulse is produced.
- Handshake: a transfer occurs at a rising edge where din_vld && din_rdy.
  - din_rdy = (state==IDLE), decoded from a registered state.
  - din is captured into a shift register at the transfer edge.
  - din/din_vld are ignored while busy.
- FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - PARITY is skipped when PARITY=0.
  - Each non-IDLE state advances on a bit tick.
  - The bit tick is the baud counter reaching CLK_DIV-1. The counter then wraps to 0.
- Baud counter: width $clog2(CLK_DIV). It runs only outside IDLE and is cleared on the transfer edge.
- Bit counter: counts DATA bits 0..DATA_BITS-1, then STOP bits 0..STOP_BITS-1. It is cleared on every state change.
- dout is registered:
  - 0 from the transfer edge for exactly CLK_DIV cycles (start bit).
  - Then each data bit, LSB first, for CLK_DIV cycles each.
  - Then the parity bit, if enabled.
  - Then 1 for STOP_BITS*CLK_DIV cycles.
- Parity: even = XOR of all captured data bits; odd = inverted XOR. It is computed from the captured copy, not live din.
- Frame length: F = CLK_DIV*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) cycles, measured from the transfer edge.
- End of frame: at edge E0+F (E0 = transfer edge):
  - state becomes IDLE, tx_done=1 for one cycle, busy=0, din_rdy=1, dout stays 1.
- Back-to-back: with din_vld held high, the next transfer is at edge E0+F+1. Start bits are therefore spaced F+1 cycles apart, giving one extra idle clock.
- busy = !din_rdy.
- Illegal parameter values cause an elaboration-time $error.

Decomposition:
- Shared package uart_pkg holds:
  - parity constants PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2;
  - the FSM state enum tx_state_t (IDLE, START, DATA, PARITY, STOP);
  - the default divisor constant BAUD_115200_50M=434.
- One sub-module, uart_baud_tick: a divisor counter with enable and sync clear, outputting a tick pulse. It is reused later by the matching receiver.

Test Plan:
- Reset behaviour: CLK_DIV=4, 8N1. Assert rst_n=0, release, wait 10 cycles -> dout=1, din_rdy=1, busy=0, tx_done never pulses.
- Single 8N1 frame: CLK_DIV=4, 8N1, send 0xA5 -> dout sequence per 4-cycle bit is 0,1,0,1,0,0,1,0,1,1. Also F=40, tx_done at E0+40, din_rdy high from E0+40.
- Parity and stop bits: CLK_DIV=4, DATA_BITS=7, even parity, STOP_BITS=2, send 0x55 -> parity bit 0 (four ones), stop high for 8 cycles, F=44. Repeat with odd parity -> parity bit 1.
- Back-to-back streaming: din_vld held high with 0x00 then 0xFF -> second start bit falls exactly 41 cycles after the first (8N1, CLK_DIV=4). Changing din mid-frame does not alter the frame on the line.
- Mid-frame reset: assert rst_n at cycle 15 of a 0x00 frame -> dout=1 immediately, no tx_done. After release, a new frame of 0x3C transmits correctly.
- Default timing: CLK_DIV=434, 8N1, send 0x41 -> each bit width is 434 cycles ±0, frame is 4340 cycles. A scoreboard UART monitor decodes 0x41.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared constants and FSM state type for the UART blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Parity modes
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // 50 MHz system clock, 115200 baud
    localparam int BAUD_115200_50M = 434;

    // Transmitter frame phases
    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_tick
//  Description : Divide-by-DIV counter with enable and synchronous clear.
//                tick is high in the last count of each bit period.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
    parameter int DIV = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    // Count system clocks within a bit period, wrapping on the tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_cfg
//  Description : Elaboration-time configurable UART transmitter with a
//                valid/ready input handshake, busy flag and frame-done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = BAUD_115200_50M,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = PAR_NONE,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 din_vld,
    output logic                 din_rdy,
    output logic                 dout,
    output logic                 busy,
    output logic                 tx_done
);

    // Parameter legality, reported during elaboration
    if (CLK_DIV < 2) begin : g_bad_clk_div
        $error("uart_tx_cfg: CLK_DIV must be 2 or more");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_parity
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end

    // Bit counter only needs to reach DATA_BITS-1 (stop count is at most 1)
    localparam int            BW        = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    tx_state_t              state, state_nxt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_bit;
    logic [BW-1:0]          bit_cnt;
    logic                   dout_r, dout_nxt;
    logic                   done_r, done_nxt;
    logic                   shift, bit_inc;
    logic                   xfer, tick;

    assign din_rdy = (state == TX_IDLE);
    assign busy    = !din_rdy;
    assign xfer    = din_vld && din_rdy;
    assign dout    = dout_r;
    assign tx_done = done_r;

    uart_baud_tick #(
        .DIV (CLK_DIV)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state != TX_IDLE),
        .clr   (xfer),
        .tick  (tick)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= TX_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, next line level and datapath controls
    always_comb begin
        state_nxt = state;
        dout_nxt  = dout_r;
        done_nxt  = 1'b0;
        shift     = 1'b0;
        bit_inc   = 1'b0;
        case (state)
            TX_IDLE: begin
                if (xfer) begin
                    state_nxt = TX_START;
                    dout_nxt  = 1'b0;
                end
            end
            TX_START: begin
                if (tick) begin
                    state_nxt = TX_DATA;
                    dout_nxt  = shreg[0];
                    shift     = 1'b1;
                end
            end
            TX_DATA: begin
                if (tick) begin
                    if (bit_cnt == LAST_DATA) begin
                        if (PARITY != PAR_NONE) begin
                            state_nxt = TX_PARITY;
                            dout_nxt  = par_bit;
                        end else begin
                            state_nxt = TX_STOP;
                            dout_nxt  = 1'b1;
                        end
                    end else begin
                        dout_nxt = shreg[0];
                        shift    = 1'b1;
                        bit_inc  = 1'b1;
                    end
                end
            end
            TX_PARITY: begin
                if (tick) begin
                    state_nxt = TX_STOP;
                    dout_nxt  = 1'b1;
                end
            end
            TX_STOP: begin
                if (tick) begin
                    if (bit_cnt == LAST_STOP) begin
                        state_nxt = TX_IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        bit_inc = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = TX_IDLE;
                dout_nxt  = 1'b1;
            end
        endcase
    end

    // Capture payload and its parity at the handshake, then shift LSB first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            par_bit <= 1'b0;
        end else if (xfer) begin
            shreg   <= din;
            par_bit <= (PARITY == PAR_ODD) ? ~^din : ^din;
        end else if (shift) begin
            shreg <= shreg >> 1;
        end
    end

    // Bit counter restarts at every phase change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
        end else if (state_nxt != state) begin
            bit_cnt <= '0;
        end else if (bit_inc) begin
            bit_cnt <= bit_cnt + BW'(1);
        end
    end

    // Registered line driver and end-of-frame pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_r <= 1'b1;
            done_r <= 1'b0;
        end else begin
            dout_r <= dout_nxt;
            done_r <= done_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_cfg
//  Description : Scoreboard bench for uart_tx_cfg over four configurations
//                (8N1 /4, 7E2 /4, 7O2 /4, 8N1 /434).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_cfg;

    int   checks = 0;
    int   errors = 0;
    logic clk = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;

    // Cycle index: value n after the n-th rising edge
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int data;
        int e0;
    } item_t;

    task automatic check(input string name, input int inst,
                         input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d cyc=%0d actual=%0h required=%0h",
                     name, inst, cyc, act, exp);
        end
    endtask

    function automatic int div_of(input int i);
        return (i == 3) ? 434 : 4;
    endfunction
    function automatic int db_of(input int i);
        return (i == 1 || i == 2) ? 7 : 8;
    endfunction
    function automatic int par_of(input int i);
        return (i == 1) ? 2 : (i == 2) ? 1 : 0;
    endfunction
    function automatic int sb_of(input int i);
        return (i == 1 || i == 2) ? 2 : 1;
    endfunction
    function automatic int first_of(input int i);
        return (i == 0) ? 'hA5 : (i == 3) ? 'h41 : 'h55;
    endfunction
    function automatic int nrand_of(input int i);
        return (i == 3) ? 2 : 12;
    endfunction

    for (genvar gi = 0; gi < 4; gi++) begin : g_inst
        localparam int DV = div_of(gi);
        localparam int DB = db_of(gi);
        localparam int PR = par_of(gi);
        localparam int SB = sb_of(gi);
        localparam int NB = 1 + DB + ((PR != 0) ? 1 : 0) + SB;
        localparam int F  = DV * NB;
        localparam int MASK = (1 << DB) - 1;

        logic          rst_n;
        logic [DB-1:0] din;
        logic          din_vld;
        logic          din_rdy, dout, busy, tx_done;
        bit            fin = 1'b0;
        int            drv_next_ok = 0;
        item_t         q[$];

        uart_tx_cfg #(
            .CLK_DIV   (DV),
            .DATA_BITS (DB),
            .PARITY    (PR),
            .STOP_BITS (SB)
        ) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .din     (din),
            .din_vld (din_vld),
            .din_rdy (din_rdy),
            .dout    (dout),
            .busy    (busy),
            .tx_done (tx_done)
        );

        // Reference line level of bit slot idx of a frame carrying d
        function automatic logic exp_bit(input int d, input int idx);
            int ones;
            if (idx == 0) return 1'b0;
            if (idx <= DB) return logic'((d >> (idx - 1)) & 1);
            if (PR != 0 && idx == DB + 1) begin
                ones = $countones(d & MASK);
                return (PR == 2) ? logic'(ones % 2) : logic'(1 - ones % 2);
            end
            return 1'b1;
        endfunction

        // Offer d; the model decides at which edge the transmitter takes it
        task automatic xfer(input int d, input bit drop);
            bit taken = 1'b0;
            int m;
            din     = DB'(d);
            din_vld = 1'b1;
            while (!taken) begin
                m = cyc + 1;
                if (m >= drv_next_ok) begin
                    q.push_back('{d & MASK, m});
                    drv_next_ok = m + F + 1;
                    taken = 1'b1;
                end
                @(posedge clk);
                #1;
            end
            if (drop) din_vld = 1'b0;
            din = DB'($urandom);
        endtask

        initial begin
            int gap;
            rst_n   = 1'b0;
            din     = '0;
            din_vld = 1'b0;
            repeat (3) @(posedge clk);
            #1 rst_n = 1'b1;
            repeat (10) @(posedge clk);
            #1;
            xfer(first_of(gi), 1'b1);
            repeat (F + 2) @(posedge clk);
            #1;
            xfer(0, 1'b0);
            xfer(MASK, 1'b1);
            repeat (F + 3) @(posedge clk);
            #1;
            xfer(0, 1'b1);
            repeat (14) @(posedge clk);
            #1 rst_n = 1'b0;
            #1;
            check("async_rst_dout", gi, 16'(dout), 16'd1);
            check("async_rst_busy", gi, 16'(busy), 16'd0);
            drv_next_ok = 0;
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            xfer('h3C, 1'b1);
            repeat (F + 2) @(posedge clk);
            #1;
            for (int k = 0; k < nrand_of(gi); k++) begin
                gap = $urandom_range(0, 3);
                if (gap > 0) begin
                    din_vld = 1'b0;
                    repeat (gap) @(posedge clk);
                    #1;
                end
                xfer(int'($urandom) & MASK, 1'b0);
            end
            din_vld = 1'b0;
            repeat (F + 5) @(posedge clk);
            fin = 1'b1;
        end

        item_t cur;
        bit    has_last = 1'b0;
        bit    act;
        int    rx, n, k;
        logic  edout;

        // Monitor: compare the line, handshake and done pulse every cycle
        always @(negedge clk) begin
            if (!rst_n) begin
                has_last = 1'b0;
                q.delete();
                check("rst_dout", gi, 16'(dout), 16'd1);
                check("rst_rdy", gi, 16'(din_rdy), 16'd1);
                check("rst_busy", gi, 16'(busy), 16'd0);
                check("rst_done", gi, 16'(tx_done), 16'd0);
            end else begin
                n = cyc;
                if (q.size() > 0 && q[0].e0 == n) begin
                    cur      = q.pop_front();
                    has_last = 1'b1;
                    rx       = 0;
                end
                act   = has_last && (n < cur.e0 + F);
                k     = n - cur.e0;
                edout = act ? exp_bit(cur.data, k / DV) : 1'b1;
                check("dout", gi, 16'(dout), 16'(edout));
                check("din_rdy", gi, 16'(din_rdy), 16'(!act));
                check("busy", gi, 16'(busy), 16'(act));
                check("tx_done", gi, 16'(tx_done),
                      16'(has_last && (n == cur.e0 + F)));
                if (act && (k % DV == DV / 2) && (k / DV >= 1) && (k / DV <= DB))
                    rx = rx | (int'(dout) << (k / DV - 1));
                if (act && k == F - 1)
                    check("decode", gi, 16'(rx), 16'(cur.data));
            end
        end
    end

    initial begin
        wait (g_inst[0].fin && g_inst[1].fin && g_inst[2].fin && g_inst[3].fin);
        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL timeout cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
